// File: rtl/st_channel_skid_adapter.sv
// Packetised streaming adapter: filters packets by channel, zero-extends the channel,
// flags SOP-inside-open-packet, and decouples the sink from the source with a 2-entry skid buffer.
//
// state | meaning
// IDLE  | no packet open; next beat must carry SOP
// PASS  | legal packet open; beats forwarded with latched channel
// DROP  | illegal or orphan packet open; beats discarded until EOP
module st_channel_skid_adapter #(
  parameter int DATA_W      = 8,
  parameter int IN_CHAN_W   = 1,
  parameter int OUT_CHAN_W  = 8,
  parameter int MAX_CHANNEL = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [IN_CHAN_W-1:0]  in_channel,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [OUT_CHAN_W-1:0] out_channel,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic                  out_error,
  output logic [15:0]           drop_count
);

  generate
    if (IN_CHAN_W > OUT_CHAN_W) begin : g_bad_chan_width
      $error("st_channel_skid_adapter: IN_CHAN_W must not exceed OUT_CHAN_W");
    end
  endgenerate

  localparam bit RANGE_CHK = MAX_CHANNEL < (2 ** IN_CHAN_W);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [OUT_CHAN_W-1:0] chan;
    logic                  sop;
    logic                  eop;
    logic                  err;
  } beat_t;

  state_t                state, state_nxt;
  logic [OUT_CHAN_W-1:0] chan_q, chan_nxt, chan_ext;
  beat_t                 head, head_nxt, skid, skid_nxt, beat_new;
  logic                  head_vld, head_vld_nxt, skid_vld, skid_vld_nxt;
  logic                  rdy_q, accept, pop, fwd, drop_inc, chan_ok;

  assign chan_ext = OUT_CHAN_W'(in_channel);
  assign chan_ok  = !RANGE_CHK || (32'(in_channel) <= $unsigned(MAX_CHANNEL));
  assign accept   = in_valid && rdy_q;
  assign pop      = head_vld && out_ready;

  always_comb begin
    state_nxt     = state;
    chan_nxt      = chan_q;
    fwd           = 1'b0;
    drop_inc      = 1'b0;
    beat_new.data = in_data;
    beat_new.chan = in_startofpacket ? chan_ext : chan_q;
    beat_new.sop  = in_startofpacket;
    beat_new.eop  = in_endofpacket;
    beat_new.err  = 1'b0;
    if (accept) begin
      if (in_startofpacket) begin
        if (chan_ok) begin
          fwd          = 1'b1;
          beat_new.err = (state == PASS);
          chan_nxt     = chan_ext;
          state_nxt    = in_endofpacket ? IDLE : PASS;
        end else begin
          drop_inc  = 1'b1;
          state_nxt = in_endofpacket ? IDLE : DROP;
        end
      end else begin
        case (state)
          PASS: begin
            fwd       = 1'b1;
            state_nxt = in_endofpacket ? IDLE : PASS;
          end
          DROP: state_nxt = in_endofpacket ? IDLE : DROP;
          default: begin
            // first beat of an orphan run; the rest of the run is absorbed in DROP
            drop_inc  = 1'b1;
            state_nxt = in_endofpacket ? IDLE : DROP;
          end
        endcase
      end
    end
  end

  // head is the output register; skid only fills while head is stalled
  always_comb begin
    head_nxt     = head;
    head_vld_nxt = head_vld;
    skid_nxt     = skid;
    skid_vld_nxt = skid_vld;
    if (pop) begin
      if (skid_vld) begin
        head_nxt     = skid;
        skid_vld_nxt = 1'b0;
      end else begin
        head_vld_nxt = 1'b0;
      end
    end
    if (fwd) begin
      if (!head_vld_nxt) begin
        head_nxt     = beat_new;
        head_vld_nxt = 1'b1;
      end else begin
        skid_nxt     = beat_new;
        skid_vld_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      chan_q     <= '0;
      head       <= '0;
      skid       <= '0;
      head_vld   <= 1'b0;
      skid_vld   <= 1'b0;
      rdy_q      <= 1'b0;
      drop_count <= '0;
    end else begin
      state    <= state_nxt;
      chan_q   <= chan_nxt;
      head     <= head_nxt;
      skid     <= skid_nxt;
      head_vld <= head_vld_nxt;
      skid_vld <= skid_vld_nxt;
      rdy_q    <= !skid_vld_nxt;
      if (drop_inc && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end

  assign in_ready          = rdy_q;
  assign out_valid         = head_vld;
  assign out_data          = head.data;
  assign out_channel       = head.chan;
  assign out_startofpacket = head.sop;
  assign out_endofpacket   = head.eop;
  assign out_error         = head.err;

endmodule

// File: doc/st_channel_skid_adapter.md
ST_CHANNEL_SKID_ADAPTER -- requirements
Module: st_channel_skid_adapter

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, width of in_data/out_data.
REQ-002 SHALL provide parameter IN_CHAN_W, default 1, width of in_channel.
REQ-003 SHALL provide parameter OUT_CHAN_W, default 8, width of out_channel; IN_CHAN_W > OUT_CHAN_W SHALL be an elaboration error.
REQ-004 SHALL provide parameter MAX_CHANNEL, default 255, highest legal channel number; MAX_CHANNEL >= 2**IN_CHAN_W disables range checking.
REQ-005 SHALL run on one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 in_valid / in_ready  input / output  1 / 1  sink handshake.
REQ-009 in_data  input  DATA_W  sink payload.
REQ-010 in_channel  input  IN_CHAN_W  channel number, sampled only on SOP beats.
REQ-011 in_startofpacket / in_endofpacket  input  1 / 1  packet delimiters.
REQ-012 out_valid / out_ready  output / input  1 / 1  source handshake.
REQ-013 out_data  output  DATA_W; out_channel  output  OUT_CHAN_W; out_startofpacket / out_endofpacket  output  1 / 1.
REQ-014 out_error  output  1  set on a forwarded beat that carries an SOP while a packet was already open.
REQ-015 drop_count  output  16  count of packets discarded for illegal channel or missing SOP.

Function
REQ-016 Beat accepted when in_valid && in_ready; forwarded beat completes when out_valid && out_ready.
REQ-017 SHALL hold a 2-entry skid buffer; in_ready SHALL be a registered signal equal to "skid entry free", never combinationally dependent on out_ready.
REQ-018 Accept-to-out_valid latency SHALL be exactly 1 cycle when buffer empty; sustained throughput SHALL be 1 beat/cycle with out_ready held high.
REQ-019 While out_valid && !out_ready, all out_* payload signals SHALL remain stable.
REQ-020 Beats SHALL be forwarded in order; no forwarded beat lost or duplicated under any out_ready pattern.
REQ-021 Packet FSM states: IDLE, PASS, DROP; FSM advances only on accepted beats.
REQ-022 IDLE + SOP, channel <= MAX_CHANNEL: latch channel, forward beat; go PASS unless EOP (stay IDLE).
REQ-023 IDLE + SOP, channel > MAX_CHANNEL: discard beat, increment drop_count; go DROP unless EOP (stay IDLE).
REQ-024 IDLE + non-SOP beat: discard; enter DROP (stay IDLE if EOP); increment drop_count once per such orphan run.
REQ-025 PASS + non-SOP beat: forward with out_channel = latched channel; EOP -> IDLE.
REQ-026 PASS + SOP beat: treat as new packet per REQ-022/023, forwarded beat (if legal) carries out_error = 1.
REQ-027 DROP: discard non-SOP beats, EOP -> IDLE; SOP beat re-evaluated per REQ-022/023 without error flag.
REQ-028 Discarded beats SHALL still be accepted (in_ready behaviour unchanged) and SHALL not occupy skid entries.
REQ-029 out_channel SHALL be latched in_channel zero-extended to OUT_CHAN_W; per-beat in_channel ignored after SOP.
REQ-030 drop_count SHALL saturate at 16'hFFFF.
REQ-031 Single-beat packet (SOP and EOP together) SHALL be handled in one accepted cycle with FSM ending in IDLE.

Reset
REQ-032 reset_n low SHALL asynchronously force: FSM IDLE, skid empty, out_valid 0, out_data 0, out_channel 0, out_startofpacket 0, out_endofpacket 0, out_error 0, drop_count 0, in_ready 0.
REQ-033 in_ready SHALL rise on the first clk rising edge after reset_n deasserts.
REQ-034 Reset mid-packet SHALL discard buffered beats; the next accepted beat is evaluated from IDLE.

Verification
REQ-035 4-beat packet, channel 1, out_ready=1 -> 4 beats out, 1-cycle latency, out_channel=8'h01 on all, SOP on first, EOP on last, out_error=0.
REQ-036 Same packet with out_ready toggling 1,0,0,1,... -> payload stable while stalled, in_ready drops after 2 unaccepted beats, all 4 beats delivered in order.
REQ-037 MAX_CHANNEL=0, 3-beat packet channel 1 then 2-beat packet channel 0 -> first packet absent at output, drop_count=1, second packet forwarded intact.
REQ-038 SOP beat, 1 data beat, then SOP (channel 0) without EOP, EOP -> third forwarded beat out_error=1, out_channel=0, FSM IDLE after EOP.
REQ-039 Orphan non-SOP beats 0xAA,0xBB(EOP) from IDLE -> nothing forwarded, drop_count=1; reset_n pulsed low mid-packet -> all outputs 0 immediately, in_ready=1 one edge after release.
